pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Splits a WIDTH-bit operation into NUM_BLOCKS = WIDTH/BLOCK lookahead groups, one group per pipeline stage. The carry is registered between stages.
- Adds subtract mode, signed-overflow and carry-out flags, and a valid/ready handshake with backpressure, none of which the fixed 8-bit group has.

Parameters:
- WIDTH, 32, operand and result width. Must be a multiple of BLOCK.
- BLOCK, 8, bits per lookahead group. Legal range 2..16.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and op are presented this cycle
- in_ready  out  1  adder accepts an operation this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B (B inverted, carry-in 1)
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes the result this cycle
- S  out  WIDTH  sum/difference
- carry_out  out  1  carry out of the MSB; for subtract, 1 = no borrow
- overflow  out  1  signed overflow

Behaviour:
- Reset (reset_n low, asynchronous): every pipeline register clears to 0, including all valid bits, S, carry_out and overflow. out_valid=0. Reset asserted mid-operation discards all in-flight operations. in_ready is combinational and follows the advance rule below.
- Global advance: advance = !out_valid | out_ready. in_ready = advance. Every stage register loads only when advance=1; otherwise all stages hold.
- Accept: an operation is accepted when in_valid & in_ready.
- Stage 0 on accept:
  - Register A, sub, and B' = B ^ {WIDTH{sub}}.
  - Compute slice 0 with carry-in = sub.
- Stage k (1..NUM_BLOCKS-1): computes slice k from delayed operand bits and the carry registered by stage k-1.
- Skew alignment: upper operand slices are delayed to line up with their stage. Lower result slices are delayed so that all slices reach S in the same cycle.
- Latency: exactly NUM_BLOCKS advancing cycles from accept to out_valid=1 (4 for defaults; 1 when NUM_BLOCKS=1). Throughput is one operation per cycle when out_ready stays high.
- Bubbles: a cycle with in_valid=0 and advance=1 inserts a bubble (valid bit 0) that propagates through the pipe. Bubbles are not collapsed.
- Backpressure: when out_valid=1 and out_ready=0, S, carry_out, overflow and out_valid hold stable and in_ready=0. A result is consumed and a new one loaded in the same cycle when out_ready=1.
- Flags:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Both flags are registered alongside S and are meaningful only while out_valid=1.
- Ordering: results leave in accept order. None is dropped or duplicated.

Decomposition:
- Shared package, alu_pkg:
  - OP_ADD=0, OP_SUB=1 encoding for the sub input.
  - Function clog2.
  - Parameter legality check (WIDTH % BLOCK == 0).
- Sub-module cla_group (parameter BLOCK), purely combinational:
  - Inputs: a, b, c_in.
  - Outputs: s, c_out, c_msb_in (carry into the group's top bit, used for overflow), and group P/G.
  - Internals: per-bit p=a^b, g=a&b; full lookahead carries.
- Instantiate cla_group NUM_BLOCKS times with a generate loop. All registers live in the top module.

Test Plan:
- Add wrap: WIDTH=32/BLOCK=8, A=0xFFFFFFFF, B=0x00000001, sub=0, out_ready=1 -> exactly 4 cycles later out_valid=1, S=0x00000000, carry_out=1, overflow=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, sub=0 -> S=0x80000000, overflow=1, carry_out=0. Then A=0x80000000, B=0x00000001, sub=1 -> S=0x7FFFFFFF, overflow=1, carry_out=1.
- Borrow: A=5, B=7, sub=1 -> S=0xFFFFFFFE, carry_out=0, overflow=0.
- Streaming with backpressure: issue 6 back-to-back ops (A=i, B=0x10*i, i=1..6). Hold out_ready=0 from the cycle the first result appears for 3 cycles, then release -> in_ready=0 during the hold, S=0x11*i delivered in order, outputs stable during the hold, no loss or duplication.
- Bubbles: alternate in_valid 1/0 for 8 cycles with out_ready=1 -> out_valid alternates with the same pattern delayed by 4 cycles, and each result is correct.
- Reset mid-flight: accept 3 ops, pulse reset_n low for one cycle (asynchronously, mid-cycle) -> out_valid, S and flags go to 0 immediately, no stale result ever appears, and a new op after reset completes with latency 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding for the adder's sub input
// and elaboration-time helpers for checking the adder's configuration.
package alu_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   function automatic bit cfg_legal(input int width, input int block);
      return (block >= 2) && (block <= 16) && (width >= block) && ((width % block) == 0);
   endfunction

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: every internal carry is a flat sum of
// generate/propagate products, so no carry ripples through the group.
module cla_group #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             c_in,
   output logic [BLOCK-1:0] s,
   output logic             c_out,
   output logic             c_msb_in,
   output logic             p_grp,
   output logic             g_grp
);

   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] g;
   logic [BLOCK:0]   c;
   logic             prod;
   logic             gen;

   assign p = a ^ b;
   assign g = a & b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in, built term by term
   always_comb begin
      c     = '0;
      c[0]  = c_in;
      prod  = 1'b1;
      gen   = 1'b0;
      g_grp = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
         prod = 1'b1;
         gen  = 1'b0;
         for (int j = i; j >= 0; j--) begin
            gen  = gen | (g[j] & prod);
            prod = prod & p[j];
         end
         c[i+1] = gen | (prod & c_in);
         if (i == BLOCK - 1) begin
            g_grp = gen;
         end
      end
   end

   assign s        = p ^ c[BLOCK-1:0];
   assign c_out    = c[BLOCK];
   assign c_msb_in = c[BLOCK-1];
   assign p_grp    = &p;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one lookahead group per stage, carry registered
// between stages, with a single global advance shared by every stage.
module pipelined_cla_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NUM_BLOCKS = WIDTH / BLOCK;

   if (!cfg_legal(WIDTH, BLOCK)) begin : bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK and BLOCK in 2..16");
   end

   logic             advance;
   logic             sub_in;
   logic [WIDTH-1:0] b_inv;

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;
   assign sub_in   = (sub == OP_SUB);
   assign b_inv    = B ^ {WIDTH{sub_in}};

   for (genvar k = 0; k < NUM_BLOCKS; k++) begin : stage
      // Operand bits not yet consumed when entering this stage, this slice included
      localparam int REM = WIDTH - k * BLOCK;

      logic [REM-1:0]         a_src;
      logic [REM-1:0]         b_src;
      logic                   c_src;
      logic                   v_src;
      logic [BLOCK-1:0]       grp_s;
      logic                   grp_cout;
      logic                   grp_cmsb;
      logic                   grp_p;
      logic                   grp_g;
      logic                   c_next;
      logic [(k+1)*BLOCK-1:0] s_next;
      logic [(k+1)*BLOCK-1:0] s_r;
      logic                   c_r;
      logic                   v_r;

      if (k == 0) begin : head
         assign a_src  = A;
         assign b_src  = b_inv;
         assign c_src  = sub_in;
         assign v_src  = in_valid;
         assign s_next = grp_s;
      end else begin : body
         assign a_src  = stage[k-1].ops.a_r;
         assign b_src  = stage[k-1].ops.b_r;
         assign c_src  = stage[k-1].c_r;
         assign v_src  = stage[k-1].v_r;
         assign s_next = {grp_s, stage[k-1].s_r};
      end

      cla_group #(.BLOCK(BLOCK)) u_group (
         .a        (a_src[BLOCK-1:0]),
         .b        (b_src[BLOCK-1:0]),
         .c_in     (c_src),
         .s        (grp_s),
         .c_out    (grp_cout),
         .c_msb_in (grp_cmsb),
         .p_grp    (grp_p),
         .g_grp    (grp_g)
      );

      // Inner stages forward the carry from group P/G; the last uses the MSB carry
      assign c_next = (k == NUM_BLOCKS - 1) ? grp_cout : (grp_g | (grp_p & c_src));

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            s_r <= '0;
            c_r <= 1'b0;
            v_r <= 1'b0;
         end else if (advance) begin
            s_r <= s_next;
            c_r <= c_next;
            v_r <= v_src;
         end
      end

      if (k < NUM_BLOCKS - 1) begin : ops
         logic [REM-BLOCK-1:0] a_r;
         logic [REM-BLOCK-1:0] b_r;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               a_r <= '0;
               b_r <= '0;
            end else if (advance) begin
               a_r <= a_src[REM-1:BLOCK];
               b_r <= b_src[REM-1:BLOCK];
            end
         end
      end else begin : tail
         logic ovf_r;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               ovf_r <= 1'b0;
            end else if (advance) begin
               ovf_r <= grp_cmsb ^ grp_cout;
            end
         end
      end
   end

   assign S         = stage[NUM_BLOCKS-1].s_r;
   assign carry_out = stage[NUM_BLOCKS-1].c_r;
   assign out_valid = stage[NUM_BLOCKS-1].v_r;
   assign overflow  = stage[NUM_BLOCKS-1].tail.ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (32-bit, 8-bit groups, latency 4).
module tb_pipelined_cla_adder;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] S;
   logic        carry_out;
   logic        overflow;

   int checks;
   int errors;

   pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Present one operation for a single accepting edge, then withdraw it
   task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      A = a;
      B = b;
      sub = s;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges from the accepting edge until out_valid rises (bounded)
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (S !== 32'h0) begin errors++; $display("[TB] FAIL reset_S got %h want 00000000", S); end
      checks++; if ({carry_out, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b want 00", {carry_out, overflow}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_add_wrap();
      int lat;
      send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_out(lat);
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL wrap_latency got %0d want 4", lat); end
      checks++; if (S !== 32'h0000_0000) begin errors++; $display("[TB] FAIL wrap_S got %h want 00000000", S); end
      checks++; if ({carry_out, overflow} !== 2'b10) begin errors++; $display("[TB] FAIL wrap_flags got c=%b v=%b want c=1 v=0", carry_out, overflow); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_overflow();
      int lat;
      send_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_out(lat);
      checks++; if (S !== 32'h8000_0000) begin errors++; $display("[TB] FAIL ovf_add_S got %h want 80000000", S); end
      checks++; if ({carry_out, overflow} !== 2'b01) begin errors++; $display("[TB] FAIL ovf_add_flags got c=%b v=%b want c=0 v=1", carry_out, overflow); end
      @(posedge clock);
      #1;
      send_op(32'h8000_0000, 32'h0000_0001, 1'b1);
      wait_out(lat);
      checks++; if (S !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL ovf_sub_S got %h want 7fffffff", S); end
      checks++; if ({carry_out, overflow} !== 2'b11) begin errors++; $display("[TB] FAIL ovf_sub_flags got c=%b v=%b want c=1 v=1", carry_out, overflow); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_borrow();
      int lat;
      send_op(32'd5, 32'd7, 1'b1);
      wait_out(lat);
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL borrow_latency got %0d want 4", lat); end
      checks++; if (S !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL borrow_S got %h want fffffffe", S); end
      checks++; if ({carry_out, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL borrow_flags got c=%b v=%b want c=0 v=0", carry_out, overflow); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_back_to_back();
      int          sent;
      int          got;
      int          hold;
      int          cyc;
      logic        seen;
      logic        accept;
      logic        consume;
      logic [31:0] held_s;
      sent = 0; got = 0; hold = 0; cyc = 0; seen = 1'b0; held_s = '0;
      while (got < 6 && cyc < 60) begin
         if (out_valid) seen = 1'b1;
         out_ready = (seen && hold < 3) ? 1'b0 : 1'b1;
         if (sent < 6) begin
            A = sent + 1;
            B = 16 * (sent + 1);
            sub = 1'b0;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready got %b want 0", in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_out_valid got %b want 1", out_valid); end
            if (hold > 0) begin
               checks++; if (S !== held_s) begin errors++; $display("[TB] FAIL hold_S_stable got %h want %h", S, held_s); end
            end
            held_s = S;
            hold++;
         end
         accept = in_valid && in_ready;
         consume = out_valid && out_ready;
         if (consume) begin
            checks++; if (S !== 32'h11 * (got + 1)) begin errors++; $display("[TB] FAIL stream_S[%0d] got %h want %h", got, S, 32'h11 * (got + 1)); end
            got++;
         end
         @(posedge clock);
         #1;
         if (accept) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++; if (got != 6) begin errors++; $display("[TB] FAIL stream_count got %0d want 6", got); end
      checks++; if (hold != 3) begin errors++; $display("[TB] FAIL stream_hold_cycles got %0d want 3", hold); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_no_dup got %b want 0", out_valid); end
   endtask

   task automatic test_bubbles();
      logic [31:0] exp_q[$];
      logic [31:0] exp_s;
      logic        exp_v;
      out_ready = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         if (n <= 8 && ((n - 1) % 2 == 0)) begin
            A = 32'h1000 * n;
            B = n + 7;
            sub = (n == 3) ? 1'b1 : 1'b0;
            in_valid = 1'b1;
            exp_q.push_back(sub ? (A - B) : (A + B));
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clock);
         #1;
         exp_v = (n >= 4) && (n <= 11) && ((n - 4) % 2 == 0);
         checks++; if (out_valid !== exp_v) begin errors++; $display("[TB] FAIL bubble_valid[%0d] got %b want %b", n, out_valid, exp_v); end
         if (out_valid && exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            checks++; if (S !== exp_s) begin errors++; $display("[TB] FAIL bubble_S[%0d] got %h want %h", n, S, exp_s); end
         end
      end
      in_valid = 1'b0;
      checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bubble_left got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_midflight();
      int   lat;
      logic stale;
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         A = 32'd100 + i;
         B = 32'd1;
         sub = 1'b0;
         in_valid = 1'b1;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      checks++; if (out_valid !== 1'b1 || S !== 32'd102) begin errors++; $display("[TB] FAIL pre_reset_result got v=%b S=%h want v=1 S=00000066", out_valid, S); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid got %b want 0", out_valid); end
      checks++; if (S !== 32'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL midreset_clear got S=%h c=%b v=%b want 0", S, carry_out, overflow); end
      #9;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) stale = 1'b1;
         @(posedge clock);
         #1;
      end
      checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stale got %b want 0", stale); end
      send_op(32'h1234_5678, 32'h1111_1111, 1'b0);
      wait_out(lat);
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL postreset_latency got %0d want 4", lat); end
      checks++; if (S !== 32'h2345_6789) begin errors++; $display("[TB] FAIL postreset_S got %h want 23456789", S); end
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      in_valid = 1'b0;
      A = '0;
      B = '0;
      sub = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_add_wrap();
      test_overflow();
      test_borrow();
      test_back_to_back();
      test_bubbles();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
